// File: rtl/mipi_rx_timing_recovery_pkg.sv
// DSI RX shared constants: packet data types, FSM encoding, default frame geometry.
package mipi_dsi_pkg;

  localparam logic [5:0] DT_VSS   = 6'h01;
  localparam logic [5:0] DT_HSS   = 6'h21;
  localparam logic [5:0] DT_BLANK = 6'h19;
  localparam logic [5:0] DT_NULL  = 6'h09;
  localparam logic [5:0] DT_RGB   = 6'h3E;

  localparam logic [11:0] RX_VACTIVE_DEF = 12'd1920;
  localparam logic [15:0] RX_HBYTES_DEF  = 16'd3240;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_LINE = 3'd1;
  localparam logic [2:0] ST_HSS_SEEN  = 3'd2;
  localparam logic [2:0] ST_PAYLOAD   = 3'd3;
  localparam logic [2:0] ST_DROP      = 3'd4;

  // Byte-lane mask for a beat with `rem` bytes still expected in the line.
  function automatic logic [3:0] keep_mask(input logic [15:0] rem);
    if (rem >= 16'd4) return 4'hF;
    return 4'((5'd1 << rem[1:0]) - 5'd1);
  endfunction

endpackage

// File: rtl/mipi_rx_timing_recovery_if.sv
// Bundle between the RX PHY/pixel FIFO side (master) and the timing recovery block (slave).
interface mipi_rx_timing_recovery_if;
  logic        Rx_hdr_valid;
  logic [5:0]  Rx_hdr_data_type;
  logic [15:0] Rx_hdr_word_count;
  logic        Rx_payload_valid;
  logic [31:0] Rx_payload;
  logic        Rx_payload_last;
  logic        Err_clr;
  logic        Fifo_full;
  logic        Vsync;
  logic        Hsync;
  logic        frame_active;
  logic        frame_done;
  logic [11:0] line_cnt;
  logic        Fifo_wr_en;
  logic [31:0] Fifo_wdata;
  logic [3:0]  Fifo_keep;
  logic        err_len;
  logic        err_proto;
  logic        err_ovf;
  logic [15:0] Err_count;

  modport master (
    output Rx_hdr_valid, Rx_hdr_data_type, Rx_hdr_word_count, Rx_payload_valid,
           Rx_payload, Rx_payload_last, Err_clr, Fifo_full,
    input  Vsync, Hsync, frame_active, frame_done, line_cnt, Fifo_wr_en,
           Fifo_wdata, Fifo_keep, err_len, err_proto, err_ovf, Err_count
  );

  modport slave (
    input  Rx_hdr_valid, Rx_hdr_data_type, Rx_hdr_word_count, Rx_payload_valid,
           Rx_payload, Rx_payload_last, Err_clr, Fifo_full,
    output Vsync, Hsync, frame_active, frame_done, line_cnt, Fifo_wr_en,
           Fifo_wdata, Fifo_keep, err_len, err_proto, err_ovf, Err_count
  );
endinterface

// File: rtl/mipi_rx_timing_recovery.sv
// DSI video-mode RX timing recovery: packet decode, sync regeneration, RGB888 push to pixel FIFO.
// Define MIPI_RX_ERR_CNT_EN to build the saturating error event counter on Err_count.
module mipi_rx_timing_recovery
  import mipi_dsi_pkg::*;
#(
  parameter logic [11:0] RX_VACTIVE = RX_VACTIVE_DEF,
  parameter logic [15:0] RX_HBYTES  = RX_HBYTES_DEF
) (
  input logic                      CLK_tx,
  input logic                      RSTn,
  mipi_rx_timing_recovery_if.slave bus
);

  logic [2:0]  state, st_nxt, eff;
  logic [15:0] byte_cnt, bc_nxt;
  logic [11:0] line_inc;
  logic        close_line, enter_pl, vss_clr, vs, hs, wr;
  logic        ev_len, ev_proto, ev_ovf;
  logic [3:0]  keep;

  assign line_inc = bus.line_cnt + 12'd1;

  always_comb begin
    st_nxt     = state;
    eff        = state;
    bc_nxt     = byte_cnt;
    close_line = 1'b0;
    enter_pl   = 1'b0;
    vss_clr    = 1'b0;
    vs         = 1'b0;
    hs         = 1'b0;
    wr         = 1'b0;
    keep       = 4'h0;
    ev_len     = 1'b0;
    ev_proto   = 1'b0;
    ev_ovf     = 1'b0;
    if (bus.Rx_hdr_valid) begin
      // A header inside a packet truncates it; the new header then decodes as if from WAIT_LINE.
      if (state == ST_PAYLOAD || state == ST_DROP) begin
        ev_proto   = 1'b1;
        close_line = (state == ST_PAYLOAD);
        eff        = ST_WAIT_LINE;
        st_nxt     = ST_WAIT_LINE;
      end
      case (bus.Rx_hdr_data_type)
        DT_VSS: begin
          vs      = 1'b1;
          vss_clr = 1'b1;
          st_nxt  = ST_WAIT_LINE;
        end
        DT_HSS: begin
          hs = 1'b1;
          if (eff != ST_IDLE) st_nxt = ST_HSS_SEEN;
        end
        DT_RGB: begin
          if (eff == ST_WAIT_LINE) begin
            st_nxt   = ST_DROP;
            ev_proto = 1'b1;
          end else if (eff == ST_HSS_SEEN) begin
            if (bus.Rx_hdr_word_count != RX_HBYTES) begin
              st_nxt = ST_DROP;
              ev_len = 1'b1;
            end else if (bus.line_cnt == RX_VACTIVE) begin
              st_nxt   = ST_DROP;
              ev_proto = 1'b1;
            end else begin
              st_nxt   = ST_PAYLOAD;
              enter_pl = 1'b1;
              bc_nxt   = 16'd0;
            end
          end
        end
        default: ;
      endcase
    end else if (bus.Rx_payload_valid) begin
      if (state == ST_PAYLOAD) begin
        if (byte_cnt >= RX_HBYTES) begin
          ev_len = 1'b1;
        end else begin
          keep   = keep_mask(RX_HBYTES - byte_cnt);
          bc_nxt = byte_cnt + 16'd4;
          if (bus.Fifo_full) ev_ovf = 1'b1;
          else               wr     = 1'b1;
        end
        if (bus.Rx_payload_last) begin
          close_line = 1'b1;
          st_nxt     = ST_WAIT_LINE;
          if ({1'b0, byte_cnt} + 17'd4 < {1'b0, RX_HBYTES}) ev_len = 1'b1;
        end
      end else if (state == ST_DROP && bus.Rx_payload_last) begin
        st_nxt = ST_WAIT_LINE;
      end
    end
  end

  always_ff @(posedge CLK_tx or negedge RSTn) begin
    if (!RSTn) begin
      state            <= ST_IDLE;
      byte_cnt         <= 16'd0;
      bus.Vsync        <= 1'b0;
      bus.Hsync        <= 1'b0;
      bus.frame_active <= 1'b0;
      bus.frame_done   <= 1'b0;
      bus.line_cnt     <= 12'd0;
      bus.Fifo_wr_en   <= 1'b0;
      bus.Fifo_wdata   <= 32'd0;
      bus.Fifo_keep    <= 4'h0;
      bus.err_len      <= 1'b0;
      bus.err_proto    <= 1'b0;
      bus.err_ovf      <= 1'b0;
    end else begin
      state          <= st_nxt;
      byte_cnt       <= bc_nxt;
      bus.Vsync      <= vs;
      bus.Hsync      <= hs;
      bus.frame_done <= 1'b0;
      bus.Fifo_wr_en <= wr;
      if (wr) begin
        bus.Fifo_wdata <= bus.Rx_payload;
        bus.Fifo_keep  <= keep;
      end
      if (vss_clr) begin
        bus.line_cnt     <= 12'd0;
        bus.frame_active <= 1'b0;
      end else begin
        if (enter_pl) bus.frame_active <= 1'b1;
        if (close_line) begin
          bus.line_cnt <= line_inc;
          if (line_inc == RX_VACTIVE) begin
            bus.frame_active <= 1'b0;
            bus.frame_done   <= 1'b1;
          end
        end
      end
      // A same-cycle event beats Err_clr so the flag stays set.
      bus.err_len   <= ev_len   | (bus.err_len   & ~bus.Err_clr);
      bus.err_proto <= ev_proto | (bus.err_proto & ~bus.Err_clr);
      bus.err_ovf   <= ev_ovf   | (bus.err_ovf   & ~bus.Err_clr);
    end
  end

`ifdef MIPI_RX_ERR_CNT_EN
  logic        ev_any;
  logic [15:0] err_cnt_q;
  assign ev_any = ev_len | ev_proto | ev_ovf;
  always_ff @(posedge CLK_tx or negedge RSTn) begin
    if (!RSTn)                              err_cnt_q <= 16'd0;
    else if (bus.Err_clr)                   err_cnt_q <= {15'd0, ev_any};
    else if (ev_any && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
  end
  assign bus.Err_count = err_cnt_q;
`else
  assign bus.Err_count = 16'h0;
`endif

endmodule
